spi_7seg_rx: RTL and testbench
==============================

Name: spi_7seg_rx

Overview:
SPI mode-0 slave receiver that sits directly upstream of the 7-segment display driver. It oversamples the SPI pins from the HPS/header bridge on CLOCK_50 and deserialises MSB-first bytes. On each completed byte it delivers Elite_7Seg_Disp_Word plus a one-cycle Elite_7Seg_Set_Flag strobe. It also echoes the previously received byte on MISO and reports framing errors and a per-frame byte count for debug.

Parameters:
SYNC_STAGES, 2, flip-flop depth of the input synchronisers on SCLK, CS_N and MOSI; legal range 2..3.
RESET_WORD, 8'h00, value loaded into Elite_7Seg_Disp_Word and the echo register on reset.

Ports:
CLOCK_50  in  1  system clock, 50 MHz. Single clock domain.
Reset_SPI  in  1  synchronous, active-high reset.
SPI_SCLK  in  1  SPI clock, asynchronous; CPOL=0. Maximum frequency is CLOCK_50/8.
SPI_CS_N  in  1  chip select, active low, asynchronous.
SPI_MOSI  in  1  serial data in, asynchronous; MSB first.
SPI_MISO  out  1  serial data out; echo of the last completed byte.
Elite_7Seg_Disp_Word  out  8  last completed received byte.
Elite_7Seg_Set_Flag  out  1  one-cycle strobe when Disp_Word updates.
SPI_Frame_Err  out  1  sticky; set when a frame ends mid-byte.
SPI_Byte_Count  out  8  number of complete bytes in the current or last frame.

Behaviour:
Reset (Reset_SPI=1 at a CLOCK_50 edge):
- Disp_Word=RESET_WORD; echo=RESET_WORD.
- Set_Flag=0, Frame_Err=0, Byte_Count=0, MISO=0.
- FSM=IDLE; bit counter=0; shift register=0.
- Synchroniser stages reset to SCLK=0, CS_N=1, MOSI=0.
- Reset mid-frame discards the partial byte. It raises no Frame_Err and no Set_Flag.

Input conditioning:
- Each input passes through SYNC_STAGES flops.
- One extra delayed copy of synchronised SCLK and CS_N provides edge detection.
- sclk_rise = sync & ~dly; sclk_fall = ~sync & dly.
- cs_fall / cs_rise are derived the same way from synchronised CS_N.

FSM states:
- IDLE: CS_N high. On cs_fall: go to RX, bit_cnt=0, Byte_Count=0, load the echo shifter from the echo register, MISO=echo[7].
- RX, on sclk_rise: shift = {shift[6:0], MOSI_sync}; bit_cnt+1.
  - When bit_cnt was 7: Disp_Word <= {shift[6:0], MOSI_sync}; echo <= same; bit_cnt wraps to 0.
  - Set_Flag=1 for exactly the next single cycle.
  - Byte_Count+1, saturating at 255.
  - The echo shifter reloads from the new byte for the next byte.
- RX, on sclk_fall: MISO <= next echo-shifter bit (MSB first).
- RX, on cs_rise: return to IDLE. If bit_cnt≠0, Frame_Err <= 1 and the partial byte is discarded; Disp_Word is unchanged. MISO <= 0.
- Frame_Err clears only on reset or on the next cs_fall.

Timing:
- Latency is fixed. The cycle the 8th-bit SCLK rise is visible in the last sync stage, plus 1, gives Disp_Word valid and Set_Flag high together.
- From pin edge this is SYNC_STAGES+2 CLOCK_50 cycles.
- Set_Flag is never high on two consecutive cycles. CLOCK_50/8 SCLK guarantees at least 8 cycles between byte completions.

Simultaneous events:
- cs_rise in the same cycle as the 8th sclk_rise: the byte completes (Set_Flag, Disp_Word update), then IDLE, with no Frame_Err.
- cs_fall and sclk_rise in the same cycle: cs_fall wins and the SCLK edge is ignored. The master must honour CS setup time.
- SCLK edges while in IDLE: ignored.

Byte_Count and Disp_Word hold their values in IDLE.

Test Plan:
- Reset: assert Reset_SPI for 3 cycles -> Disp_Word=8'h00, Set_Flag=0, Frame_Err=0, Byte_Count=0, MISO=0, no strobe afterwards.
- Single byte: CS low, send 8'hA5 at SCLK=CLOCK_50/8, CS high -> Disp_Word=8'hA5 exactly SYNC_STAGES+2 cycles after the 8th rising pin edge, one Set_Flag pulse, Byte_Count=1, Frame_Err=0.
- Burst with echo: one frame carrying 8'h12, 8'h34, 8'h56 -> three Set_Flag pulses with Disp_Word 12/34/56, Byte_Count=3. MISO carries 8'hA5, 8'h12, 8'h34 during the respective bytes.
- Aborted frame: send 5 bits of 8'hFF, then raise CS -> Frame_Err=1, Disp_Word unchanged (8'h56), no Set_Flag. The next cs_fall clears Frame_Err.
- Edge cases: CS rise coincident with the 8th synchronised SCLK rise -> byte accepted, no Frame_Err. SCLK toggling with CS high -> no state change.
- Reset mid-byte: Reset_SPI after 4 bits, then a clean 8'h3C frame -> Disp_Word=8'h3C, single strobe, Byte_Count=1.

Source files
------------

// File: rtl/spi_7seg_rx.sv
// SPI mode-0 slave receiver feeding the 7-segment driver: MSB-first bytes in, last byte echoed on MISO.
// Latency: display word and set strobe appear SYNC_STAGES+1 CLOCK_50 edges after a pin edge lands.
// Backpressure: none; every completed byte is presented with a single-cycle strobe and overwrites the last.
//
// Ports:
//   CLOCK_50             system clock, sole clock domain
//   Reset_SPI            synchronous active-high reset
//   SPI_SCLK/CS_N/MOSI   asynchronous SPI pins (CPOL=0, CPHA=0), SCLK at most CLOCK_50/8
//   SPI_MISO             echo of the previously completed byte, MSB first
//   Elite_7Seg_Disp_Word last completed byte
//   Elite_7Seg_Set_Flag  one-cycle strobe when Disp_Word updates
//   SPI_Frame_Err        sticky, set when CS_N rises mid-byte; cleared by reset or next frame start
//   SPI_Byte_Count       complete bytes in the current/last frame, saturating at 255
module spi_7seg_rx #(
   parameter int unsigned SYNC_STAGES = 2,        // legal range 2..3
   parameter logic [7:0]  RESET_WORD  = 8'h00
) (
   input  logic       CLOCK_50,
   input  logic       Reset_SPI,
   input  logic       SPI_SCLK,
   input  logic       SPI_CS_N,
   input  logic       SPI_MOSI,
   output logic       SPI_MISO,
   output logic [7:0] Elite_7Seg_Disp_Word,
   output logic       Elite_7Seg_Set_Flag,
   output logic       SPI_Frame_Err,
   output logic [7:0] SPI_Byte_Count
);

   typedef enum logic {ST_IDLE, ST_RX} state_t;

   // Synchronisers: bit 0 is the first stage, bit SYNC_STAGES-1 the last.
   logic [SYNC_STAGES-1:0] sclk_sync_q, sclk_sync_d;
   logic [SYNC_STAGES-1:0] cs_sync_q,   cs_sync_d;
   logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;
   logic                   sclk_dly_q,  sclk_dly_d;
   logic                   cs_dly_q,    cs_dly_d;

   state_t     state_q,   state_d;
   logic [2:0] bit_cnt_q, bit_cnt_d;
   logic [7:0] shift_q,   shift_d;
   logic [7:0] disp_q,    disp_d;
   logic [7:0] echo_q,    echo_d;      // last completed byte, source for the next echo
   logic [7:0] echo_tx_q, echo_tx_d;   // byte currently being echoed on MISO
   logic       flag_q,    flag_d;
   logic       err_q,     err_d;
   logic [7:0] cnt_q,     cnt_d;
   logic       miso_q,    miso_d;

   logic sclk_s, cs_s, mosi_s;
   logic sclk_rise, sclk_fall, cs_rise, cs_fall;

   always_comb begin
      sclk_sync_d = {sclk_sync_q[SYNC_STAGES-2:0], SPI_SCLK};
      cs_sync_d   = {cs_sync_q[SYNC_STAGES-2:0],   SPI_CS_N};
      mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], SPI_MOSI};
      sclk_s      = sclk_sync_q[SYNC_STAGES-1];
      cs_s        = cs_sync_q[SYNC_STAGES-1];
      mosi_s      = mosi_sync_q[SYNC_STAGES-1];
      sclk_dly_d  = sclk_s;
      cs_dly_d    = cs_s;
      sclk_rise   = sclk_s & ~sclk_dly_q;
      sclk_fall   = ~sclk_s & sclk_dly_q;
      cs_rise     = cs_s & ~cs_dly_q;
      cs_fall     = ~cs_s & cs_dly_q;
   end

   always_comb begin
      state_d   = state_q;
      bit_cnt_d = bit_cnt_q;
      shift_d   = shift_q;
      disp_d    = disp_q;
      echo_d    = echo_q;
      echo_tx_d = echo_tx_q;
      flag_d    = 1'b0;
      err_d     = err_q;
      cnt_d     = cnt_q;
      miso_d    = miso_q;

      case (state_q)
         ST_IDLE: begin
            // SCLK activity is ignored here; a coincident SCLK edge loses to CS fall.
            if (cs_fall) begin
               state_d   = ST_RX;
               bit_cnt_d = 3'd0;
               cnt_d     = 8'd0;
               err_d     = 1'b0;
               echo_tx_d = echo_q;
               miso_d    = echo_q[7];
            end
         end
         ST_RX: begin
            if (sclk_rise) begin
               shift_d   = {shift_q[6:0], mosi_s};
               bit_cnt_d = bit_cnt_q + 3'd1;
               if (bit_cnt_q == 3'd7) begin
                  disp_d    = {shift_q[6:0], mosi_s};
                  echo_d    = {shift_q[6:0], mosi_s};
                  echo_tx_d = {shift_q[6:0], mosi_s};
                  flag_d    = 1'b1;
                  if (cnt_q != 8'hFF) begin
                     cnt_d = cnt_q + 8'd1;
                  end
               end
            end else if (sclk_fall) begin
               // After k rises bit_cnt is k mod 8, so the next bit out is echo_tx[7-k];
               // after the 8th rise this picks the MSB of the freshly reloaded byte.
               miso_d = echo_tx_q[~bit_cnt_q];
            end
            // Evaluated after the SCLK update so an 8th rise coinciding with CS rise
            // completes the byte and leaves bit_cnt_d at zero (no framing error).
            if (cs_rise) begin
               state_d = ST_IDLE;
               miso_d  = 1'b0;
               if (bit_cnt_d != 3'd0) begin
                  err_d = 1'b1;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge CLOCK_50) begin
      if (Reset_SPI) begin
         sclk_sync_q <= '0;
         cs_sync_q   <= '1;
         mosi_sync_q <= '0;
         sclk_dly_q  <= 1'b0;
         cs_dly_q    <= 1'b1;
         state_q     <= ST_IDLE;
         bit_cnt_q   <= 3'd0;
         shift_q     <= 8'd0;
         disp_q      <= RESET_WORD;
         echo_q      <= RESET_WORD;
         echo_tx_q   <= RESET_WORD;
         flag_q      <= 1'b0;
         err_q       <= 1'b0;
         cnt_q       <= 8'd0;
         miso_q      <= 1'b0;
      end else begin
         sclk_sync_q <= sclk_sync_d;
         cs_sync_q   <= cs_sync_d;
         mosi_sync_q <= mosi_sync_d;
         sclk_dly_q  <= sclk_dly_d;
         cs_dly_q    <= cs_dly_d;
         state_q     <= state_d;
         bit_cnt_q   <= bit_cnt_d;
         shift_q     <= shift_d;
         disp_q      <= disp_d;
         echo_q      <= echo_d;
         echo_tx_q   <= echo_tx_d;
         flag_q      <= flag_d;
         err_q       <= err_d;
         cnt_q       <= cnt_d;
         miso_q      <= miso_d;
      end
   end

   assign SPI_MISO             = miso_q;
   assign Elite_7Seg_Disp_Word = disp_q;
   assign Elite_7Seg_Set_Flag  = flag_q;
   assign SPI_Frame_Err        = err_q;
   assign SPI_Byte_Count       = cnt_q;

endmodule

// File: tb/tb_spi_7seg_rx.sv
// Bench for spi_7seg_rx: an SPI master drives pins on the falling clock edge and logs
// frame-level events; a reference model applies each event a fixed pipeline delay later.
// Outputs are compared every cycle, MISO is checked as the master would sample it.
module tb_spi_7seg_rx;

   localparam int unsigned SYNC = 2;
   localparam logic [7:0]  RW   = 8'h00;
   // A pin change made between edges c and c+1 shows at the outputs after edge c+LAT.
   localparam int          LAT  = SYNC + 1;

   localparam int EV_START = 0;
   localparam int EV_BYTE  = 1;
   localparam int EV_END   = 2;

   typedef struct {
      int         eff;
      int         kind;
      logic [7:0] b;
      bit         err;
   } ev_t;

   logic       CLOCK_50 = 1'b0;
   logic       Reset_SPI = 1'b1;
   logic       SPI_SCLK = 1'b0;
   logic       SPI_CS_N = 1'b1;
   logic       SPI_MOSI = 1'b0;
   logic       SPI_MISO;
   logic [7:0] Elite_7Seg_Disp_Word;
   logic       Elite_7Seg_Set_Flag;
   logic       SPI_Frame_Err;
   logic [7:0] SPI_Byte_Count;

   spi_7seg_rx #(.SYNC_STAGES(SYNC), .RESET_WORD(RW)) dut (
      .CLOCK_50             (CLOCK_50),
      .Reset_SPI            (Reset_SPI),
      .SPI_SCLK             (SPI_SCLK),
      .SPI_CS_N             (SPI_CS_N),
      .SPI_MOSI             (SPI_MOSI),
      .SPI_MISO             (SPI_MISO),
      .Elite_7Seg_Disp_Word (Elite_7Seg_Disp_Word),
      .Elite_7Seg_Set_Flag  (Elite_7Seg_Set_Flag),
      .SPI_Frame_Err        (SPI_Frame_Err),
      .SPI_Byte_Count       (SPI_Byte_Count)
   );

   always #10 CLOCK_50 = ~CLOCK_50;

   int         checks = 0;
   int         failures = 0;
   int         cyc = 0;
   int         flags_seen = 0;
   int         last_flag_cyc = -1;
   int         rise_cyc = 0;
   logic [7:0] echo_exp = RW;   // byte the master expects to read back on MISO
   ev_t        evq[$];

   // Reference model state
   logic [7:0] m_disp = RW;
   logic [7:0] m_cnt = 8'd0;
   logic       m_err = 1'b0;
   logic       m_in = 1'b0;
   logic       m_flag = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic push(input int kind, input logic [7:0] b, input bit err);
      ev_t e;
      if (!Reset_SPI) begin
         e.eff  = cyc + LAT;
         e.kind = kind;
         e.b    = b;
         e.err  = err;
         evq.push_back(e);
      end
   endtask

   // Model + per-cycle compare, evaluated 1 time unit after each rising edge.
   initial begin
      forever begin
         logic rst_at;
         ev_t  e;
         @(posedge CLOCK_50);
         rst_at = Reset_SPI;
         cyc++;
         #1;
         m_flag = 1'b0;
         if (rst_at) begin
            m_disp = RW;
            m_cnt  = 8'd0;
            m_err  = 1'b0;
            m_in   = 1'b0;
            evq.delete();
         end else begin
            while (evq.size() > 0 && evq[0].eff <= cyc) begin
               e = evq.pop_front();
               case (e.kind)
                  EV_START: begin m_in = 1'b1; m_cnt = 8'd0; m_err = 1'b0; end
                  EV_BYTE: begin
                     m_disp = e.b;
                     m_flag = 1'b1;
                     m_cnt  = (m_cnt == 8'd255) ? 8'd255 : m_cnt + 8'd1;
                  end
                  default: begin m_in = 1'b0; m_err = m_err | e.err; end
               endcase
            end
         end
         chk("disp_word", Elite_7Seg_Disp_Word, m_disp);
         chk("set_flag", Elite_7Seg_Set_Flag, m_flag);
         chk("frame_err", SPI_Frame_Err, m_err);
         chk("byte_count", SPI_Byte_Count, m_cnt);
         if (!m_in) chk("miso_idle", SPI_MISO, 1'b0);
         if (Elite_7Seg_Set_Flag === 1'b1) begin
            flags_seen++;
            last_flag_cyc = cyc;
         end
      end
   end

   task automatic ticks(input int n);
      repeat (n) @(negedge CLOCK_50);
   endtask

   task automatic frame_start();
      @(negedge CLOCK_50);
      SPI_CS_N = 1'b0;
      push(EV_START, 8'h00, 1'b0);
      ticks(8);
   endtask

   task automatic frame_end(input bit partial);
      ticks(5);
      SPI_CS_N = 1'b1;
      push(EV_END, 8'h00, partial);
      ticks(8);
   endtask

   // SCLK low 4 cycles, high 4 cycles per bit (CLOCK_50/8). MISO is sampled just
   // before each rising SCLK edge, as a mode-0 master would.
   task automatic send_bits(input logic [7:0] d, input int nbits, input bit cs_with_last);
      logic [7:0] rx;
      rx = 8'h00;
      for (int i = 0; i < nbits; i++) begin
         @(negedge CLOCK_50);
         SPI_SCLK = 1'b0;
         SPI_MOSI = d[7-i];
         ticks(4);
         rx[7-i]  = SPI_MISO;
         SPI_SCLK = 1'b1;
         if (i == 7) begin
            push(EV_BYTE, d, 1'b0);
            rise_cyc = cyc;
         end
         if (cs_with_last && i == nbits - 1) begin
            SPI_CS_N = 1'b1;
            push(EV_END, 8'h00, (nbits % 8) != 0);
         end
         ticks(3);
      end
      @(negedge CLOCK_50);
      SPI_SCLK = 1'b0;
      if (nbits == 8) begin
         chk("miso_echo", rx, echo_exp);
         echo_exp = d;
      end
   endtask

   task automatic do_reset();
      @(negedge CLOCK_50);
      Reset_SPI = 1'b1;
      SPI_CS_N  = 1'b1;
      SPI_SCLK  = 1'b0;
      SPI_MOSI  = 1'b0;
      echo_exp  = RW;
      ticks(3);
      Reset_SPI = 1'b0;
   endtask

   initial begin
      int f0;
      // Reset held from time zero for three rising edges.
      ticks(3);
      Reset_SPI = 1'b0;
      ticks(10);
      chk("reset_disp", Elite_7Seg_Disp_Word, 8'h00);
      chk("reset_flag", Elite_7Seg_Set_Flag, 1'b0);
      chk("reset_err", SPI_Frame_Err, 1'b0);
      chk("reset_cnt", SPI_Byte_Count, 8'd0);
      chk("reset_miso", SPI_MISO, 1'b0);
      chk("reset_no_strobe", flags_seen, 0);

      // Single byte 0xA5; pin edge mid-cycle, strobe in the SYNC+2-th cycle counting that one.
      f0 = flags_seen;
      frame_start();
      send_bits(8'hA5, 8, 1'b0);
      frame_end(1'b0);
      chk("single_disp", Elite_7Seg_Disp_Word, 8'hA5);
      chk("single_cnt", SPI_Byte_Count, 8'd1);
      chk("single_err", SPI_Frame_Err, 1'b0);
      chk("single_strobes", flags_seen - f0, 1);
      chk("single_latency", last_flag_cyc - rise_cyc, SYNC + 1);

      // Burst with echo of A5, 12, 34.
      f0 = flags_seen;
      frame_start();
      send_bits(8'h12, 8, 1'b0);
      send_bits(8'h34, 8, 1'b0);
      send_bits(8'h56, 8, 1'b0);
      frame_end(1'b0);
      chk("burst_disp", Elite_7Seg_Disp_Word, 8'h56);
      chk("burst_cnt", SPI_Byte_Count, 8'd3);
      chk("burst_strobes", flags_seen - f0, 3);
      chk("burst_echo_next", echo_exp, 8'h56);

      // Aborted frame: 5 bits of FF.
      f0 = flags_seen;
      frame_start();
      send_bits(8'hFF, 5, 1'b0);
      frame_end(1'b1);
      chk("abort_err", SPI_Frame_Err, 1'b1);
      chk("abort_disp", Elite_7Seg_Disp_Word, 8'h56);
      chk("abort_strobes", flags_seen - f0, 0);

      // New frame clears the error; its only byte ends with CS rising on the 8th SCLK rise.
      frame_start();
      chk("err_cleared", SPI_Frame_Err, 1'b0);
      send_bits(8'hC3, 8, 1'b1);
      ticks(10);
      chk("coinc_disp", Elite_7Seg_Disp_Word, 8'hC3);
      chk("coinc_err", SPI_Frame_Err, 1'b0);
      chk("coinc_cnt", SPI_Byte_Count, 8'd1);
      chk("coinc_strobes", flags_seen - f0, 1);

      // SCLK toggling with CS high must change nothing.
      f0 = flags_seen;
      for (int i = 0; i < 24; i++) begin
         @(negedge CLOCK_50);
         SPI_SCLK = ~SPI_SCLK;
         SPI_MOSI = 1'($urandom_range(1));
         ticks(3);
      end
      SPI_SCLK = 1'b0;
      ticks(8);
      chk("idle_sclk_disp", Elite_7Seg_Disp_Word, 8'hC3);
      chk("idle_sclk_cnt", SPI_Byte_Count, 8'd1);
      chk("idle_sclk_strobes", flags_seen - f0, 0);

      // Reset after 4 bits, then a clean 0x3C frame.
      f0 = flags_seen;
      frame_start();
      send_bits(8'hF0, 4, 1'b0);
      do_reset();
      ticks(8);
      chk("midreset_disp", Elite_7Seg_Disp_Word, RW);
      chk("midreset_err", SPI_Frame_Err, 1'b0);
      frame_start();
      send_bits(8'h3C, 8, 1'b0);
      frame_end(1'b0);
      chk("after_reset_disp", Elite_7Seg_Disp_Word, 8'h3C);
      chk("after_reset_cnt", SPI_Byte_Count, 8'd1);
      chk("after_reset_strobes", flags_seen - f0, 1);

      // Byte count saturation: 256 bytes in one frame.
      frame_start();
      for (int i = 0; i < 256; i++) begin
         send_bits(8'(i), 8, 1'b0);
      end
      frame_end(1'b0);
      chk("sat_cnt", SPI_Byte_Count, 8'd255);
      chk("sat_disp", Elite_7Seg_Disp_Word, 8'hFF);
      chk("sat_err", SPI_Frame_Err, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
